// File: rtl/acq_pkg.sv
// Shared types and helpers for the ADC acquisition sequencer.
// Holds the run state encoding and the packing of a raw ADC sample into a 16-bit word.
package acq_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        CAPTURE,
        FLUSH,
        DONE
    } acq_state_t;

    // The out-of-range flag sits in the MSB so downstream code can test it with a sign check.
    function automatic logic [SAMPLE_W-1:0] pack_sample(input logic otr, input logic [11:0] data);
        return {otr, 3'b000, data};
    endfunction

endpackage

// File: rtl/acq_pingpong_buf.sv
// Two-deep ping-pong burst buffer: one side fills sample by sample while the other drains to PSRAM.
// The fill side can be closed early, which zero-pads the slots that were never written.
module acq_pingpong_buf
    import acq_pkg::*;
#(
    parameter int BURST_WORDS = 4
) (
    input  logic                            clk_PSRAM,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [SAMPLE_W-1:0]             wr_word,
    input  logic                            close,
    input  logic                            free,
    output logic [1:0]                      full,
    output logic [$clog2(BURST_WORDS)-1:0]  slot,
    output logic [SAMPLE_W*BURST_WORDS-1:0] drain_data
);

    localparam int SLOT_W = $clog2(BURST_WORDS);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(BURST_WORDS - 1);

    logic [SAMPLE_W-1:0] mem_reg [2][BURST_WORDS];
    logic                fill_ptr_reg;
    logic                drain_ptr_reg;
    logic [1:0]          full_reg;
    logic [SLOT_W-1:0]   slot_reg;
    logic                close_partial;

    assign close_partial = close && (slot_reg != '0);

    always_ff @(posedge clk_PSRAM or posedge rst) begin
        if (rst) begin
            fill_ptr_reg  <= 1'b0;
            drain_ptr_reg <= 1'b0;
            full_reg      <= 2'b00;
            slot_reg      <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int w = 0; w < BURST_WORDS; w++) begin
                    mem_reg[b][w] <= '0;
                end
            end
        end else begin
            // Free first: when both sides are full the freed side is also the fill side,
            // and a sample landing in the same cycle must see it as empty.
            if (free) begin
                full_reg[drain_ptr_reg] <= 1'b0;
                drain_ptr_reg           <= ~drain_ptr_reg;
            end
            if (wr_en) begin
                mem_reg[fill_ptr_reg][slot_reg] <= wr_word;
                if (slot_reg == LAST_SLOT) begin
                    full_reg[fill_ptr_reg] <= 1'b1;
                    fill_ptr_reg           <= ~fill_ptr_reg;
                    slot_reg               <= '0;
                end else begin
                    slot_reg <= slot_reg + 1'b1;
                end
            end else if (close_partial) begin
                for (int w = 0; w < BURST_WORDS; w++) begin
                    if (SLOT_W'(w) >= slot_reg) begin
                        mem_reg[fill_ptr_reg][w] <= '0;
                    end
                end
                full_reg[fill_ptr_reg] <= 1'b1;
                fill_ptr_reg           <= ~fill_ptr_reg;
                slot_reg               <= '0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < BURST_WORDS; gi++) begin : g_drain
            assign drain_data[gi*SAMPLE_W +: SAMPLE_W] = mem_reg[drain_ptr_reg][gi];
        end
    endgenerate

    assign full = full_reg;
    assign slot = slot_reg;

endmodule

// File: rtl/acq_sequencer.sv
// Runs one ADC acquisition: arms the capture block, packs samples into ping-pong bursts and
// writes each full burst to PSRAM at incrementing addresses until the sample count or an abort.
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int ADDR_W      = 21,
    parameter int BURST_WORDS = 4,
    parameter int ADDR_STEP   = 8,
    parameter int CNT_W       = 24
) (
    input  logic                            clk_PSRAM,
    input  logic                            rst,
    input  logic                            acq_start,
    input  logic                            acq_abort,
    input  logic [CNT_W-1:0]                acq_num_samples,
    input  logic [ADDR_W-1:0]               acq_base_addr,
    input  logic                            adc_ready,
    input  logic [11:0]                     adc_data,
    input  logic                            adc_OTR,
    output logic                            adc_enable,
    output logic                            psram_wr_req,
    input  logic                            psram_wr_ack,
    output logic [ADDR_W-1:0]               psram_addr,
    output logic [SAMPLE_W*BURST_WORDS-1:0] psram_wr_data,
    output logic                            acq_busy,
    output logic                            acq_done,
    output logic                            acq_overrun,
    output logic [CNT_W-1:0]                acq_count
);

    localparam int SLOT_W = $clog2(BURST_WORDS);

    acq_state_t         state_reg;
    logic [CNT_W-1:0]   n_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic               req_reg;
    logic               enable_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               overrun_reg;

    logic [1:0]         buf_full;
    logic [SLOT_W-1:0]  buf_slot;
    logic               capturing;
    logic               ack_fire;
    logic               both_full;
    logic               accept;
    logic               drop;
    logic               hit_n;
    logic               close;
    logic               flush_idle;
    logic [CNT_W-1:0]   count_next;

    assign capturing  = (state_reg == ARM) || (state_reg == CAPTURE);
    assign ack_fire   = psram_wr_ack && req_reg;
    assign both_full  = &buf_full;
    // An ack in the same cycle frees the oldest buffer, so a sample arriving then still fits.
    assign accept     = capturing && adc_ready && (!both_full || ack_fire);
    assign drop       = capturing && adc_ready && both_full && !ack_fire;
    assign count_next = count_reg + 1'b1;
    assign hit_n      = accept && (count_next == n_reg);
    assign close      = (state_reg == FLUSH) && (buf_slot != '0);
    assign flush_idle = (state_reg == FLUSH) && (buf_full == 2'b00) && !req_reg && (buf_slot == '0);

    acq_pingpong_buf #(
        .BURST_WORDS (BURST_WORDS)
    ) u_buf (
        .clk_PSRAM  (clk_PSRAM),
        .rst        (rst),
        .wr_en      (accept),
        .wr_word    (pack_sample(adc_OTR, adc_data)),
        .close      (close),
        .free       (ack_fire),
        .full       (buf_full),
        .slot       (buf_slot),
        .drain_data (psram_wr_data)
    );

    always_ff @(posedge clk_PSRAM or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            n_reg       <= '0;
            count_reg   <= '0;
            addr_reg    <= '0;
            req_reg     <= 1'b0;
            enable_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            // Dropping req on the ack edge guarantees at least one idle cycle between bursts.
            if (ack_fire) begin
                req_reg  <= 1'b0;
                addr_reg <= addr_reg + ADDR_W'(ADDR_STEP);
            end else if (!req_reg && (buf_full != 2'b00)) begin
                req_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (acq_start) begin
                        count_reg   <= '0;
                        overrun_reg <= 1'b0;
                        n_reg       <= acq_num_samples;
                        addr_reg    <= acq_base_addr;
                        if (acq_num_samples == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg  <= ARM;
                            enable_reg <= 1'b1;
                            busy_reg   <= 1'b1;
                        end
                    end
                end
                ARM, CAPTURE: begin
                    if (accept) begin
                        count_reg <= count_next;
                    end
                    if (drop) begin
                        overrun_reg <= 1'b1;
                    end
                    if (hit_n || acq_abort) begin
                        state_reg  <= FLUSH;
                        enable_reg <= 1'b0;
                    end else if (adc_ready) begin
                        state_reg <= CAPTURE;
                    end
                end
                FLUSH: begin
                    if (flush_idle) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign adc_enable   = enable_reg;
    assign psram_wr_req = req_reg;
    assign psram_addr   = addr_reg;
    assign acq_busy     = busy_reg;
    assign acq_done     = done_reg;
    assign acq_overrun  = overrun_reg;
    assign acq_count    = count_reg;

endmodule

// File: tb/tb_acq_sequencer.sv
// Table-driven bench for acq_sequencer: a PSRAM responder pops expected bursts from a scoreboard.
module tb_acq_sequencer;

    localparam int ADDR_W = 21;
    localparam int BW     = 4;
    localparam int CNT_W  = 24;

    logic              clk_PSRAM = 1'b0;
    logic              rst = 1'b1;
    logic              acq_start = 1'b0;
    logic              acq_abort = 1'b0;
    logic [CNT_W-1:0]  acq_num_samples = '0;
    logic [ADDR_W-1:0] acq_base_addr = '0;
    logic              adc_ready = 1'b0;
    logic [11:0]       adc_data = '0;
    logic              adc_OTR = 1'b0;
    logic              adc_enable;
    logic              psram_wr_req;
    logic              psram_wr_ack = 1'b0;
    logic [ADDR_W-1:0] psram_addr;
    logic [16*BW-1:0]  psram_wr_data;
    logic              acq_busy;
    logic              acq_done;
    logic              acq_overrun;
    logic [CNT_W-1:0]  acq_count;

    acq_sequencer #(
        .ADDR_W      (ADDR_W),
        .BURST_WORDS (BW),
        .ADDR_STEP   (8),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_PSRAM       (clk_PSRAM),
        .rst             (rst),
        .acq_start       (acq_start),
        .acq_abort       (acq_abort),
        .acq_num_samples (acq_num_samples),
        .acq_base_addr   (acq_base_addr),
        .adc_ready       (adc_ready),
        .adc_data        (adc_data),
        .adc_OTR         (adc_OTR),
        .adc_enable      (adc_enable),
        .psram_wr_req    (psram_wr_req),
        .psram_wr_ack    (psram_wr_ack),
        .psram_addr      (psram_addr),
        .psram_wr_data   (psram_wr_data),
        .acq_busy        (acq_busy),
        .acq_done        (acq_done),
        .acq_overrun     (acq_overrun),
        .acq_count       (acq_count)
    );

    always #5 clk_PSRAM = ~clk_PSRAM;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [16*BW-1:0]  data;
    } burst_t;

    typedef struct {
        int          n;
        int          n_send;
        bit          do_abort;
        logic [20:0] base;
        int          gap;
        int          lat;
        bit          otr;
        logic [11:0] fix;
        int          exp_count;
        bit          exp_ovr;
    } vec_t;

    burst_t exp_q[$];
    vec_t   vecs[7];
    int     n_vec = 0;
    int     n_err = 0;
    int     ack_lat = 3;
    int     done_cnt = 0;
    int     en_seen = 0;
    int     req_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk_PSRAM) begin
        if (acq_done) done_cnt++;
        if (adc_enable) en_seen++;
        if (psram_wr_req) req_seen++;
    end

    // PSRAM responder: compares each new request against the scoreboard, then acks after ack_lat cycles.
    initial begin
        int     wait_cnt;
        burst_t cur;
        burst_t want;
        wait_cnt = 0;
        forever begin
            @(posedge clk_PSRAM);
            #1;
            psram_wr_ack = 1'b0;
            if (rst) begin
                wait_cnt = 0;
            end else if (psram_wr_req) begin
                wait_cnt++;
                if (wait_cnt == 1) begin
                    cur = '{addr: psram_addr, data: psram_wr_data};
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_req: addr %h data %h, none expected", psram_addr, psram_wr_data);
                    end else begin
                        want = exp_q.pop_front();
                        check("burst_addr", 64'(psram_addr), 64'(want.addr));
                        check("burst_data", psram_wr_data, want.data);
                    end
                end else begin
                    check("req_addr_stable", 64'(psram_addr), 64'(cur.addr));
                    check("req_data_stable", psram_wr_data, cur.data);
                end
                if (wait_cnt == ack_lat) begin
                    psram_wr_ack = 1'b1;
                    wait_cnt = 0;
                end
            end
        end
    end

    task automatic push_expected(input vec_t v);
        int     nb;
        burst_t b;
        nb = (v.exp_count + BW - 1) / BW;
        for (int k = 0; k < nb; k++) begin
            b.addr = v.base + 21'(k * 8);
            b.data = '0;
            for (int w = 0; w < BW; w++) begin
                if (k * BW + w < v.exp_count) begin
                    b.data[w*16 +: 16] = {v.otr, 3'b000, (v.fix != 0) ? v.fix : 12'(k * BW + w + 1)};
                end
            end
            exp_q.push_back(b);
        end
    endtask

    task automatic tick();
        @(posedge clk_PSRAM);
        #1;
    endtask

    task automatic run(input vec_t v);
        push_expected(v);
        ack_lat = v.lat;
        acq_num_samples = CNT_W'(v.n);
        acq_base_addr = v.base;
        acq_start = 1'b1;
        tick();
        acq_start = 1'b0;
        done_cnt = 0;
        en_seen = 0;
        req_seen = 0;
        if (v.n != 0) begin
            for (int c = 0; c < 10 && !adc_enable; c++) tick();
            check("enable_on", 64'(adc_enable), 64'(1));
            for (int i = 1; i <= v.n_send; i++) begin
                adc_data = (v.fix != 0) ? v.fix : 12'(i);
                adc_OTR = v.otr;
                adc_ready = 1'b1;
                tick();
                adc_ready = 1'b0;
                if (i == v.exp_count && v.exp_count == v.n) begin
                    check("enable_off_after_last", 64'(adc_enable), 64'(0));
                end
                for (int g = 1; g < v.gap; g++) tick();
            end
            if (v.do_abort) begin
                acq_abort = 1'b1;
                tick();
                acq_abort = 1'b0;
            end
        end
        for (int c = 0; c < 400 && done_cnt == 0; c++) tick();
        repeat (3) tick();
        check("done_pulses", 64'(done_cnt), 64'(1));
        check("acq_count", 64'(acq_count), 64'(v.exp_count));
        check("acq_overrun", 64'(acq_overrun), 64'(v.exp_ovr));
        check("busy_after_done", 64'(acq_busy), 64'(0));
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        if (v.n == 0) begin
            check("n0_enable_cycles", 64'(en_seen), 64'(0));
            check("n0_req_cycles", 64'(req_seen), 64'(0));
        end
        $display("run n=%0d base=%h count=%0d overrun=%0d done=%0d", v.n, v.base, acq_count, acq_overrun, done_cnt);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_enable"}, 64'(adc_enable), 64'(0));
        check({tag, "_req"}, 64'(psram_wr_req), 64'(0));
        check({tag, "_addr"}, 64'(psram_addr), 64'(0));
        check({tag, "_data"}, psram_wr_data, 64'(0));
        check({tag, "_busy"}, 64'(acq_busy), 64'(0));
        check({tag, "_done"}, 64'(acq_done), 64'(0));
        check({tag, "_overrun"}, 64'(acq_overrun), 64'(0));
        check({tag, "_count"}, 64'(acq_count), 64'(0));
    endtask

    initial begin
        // n, n_send, abort, base, gap, lat, otr, fix, exp_count, exp_ovr
        vecs[0] = '{8,   8,  0, 21'h000100, 4, 3,  0, 12'h000, 8, 0};
        vecs[1] = '{6,   6,  0, 21'h000100, 4, 3,  0, 12'h000, 6, 0};
        vecs[2] = '{100, 5,  1, 21'h000040, 2, 3,  0, 12'h000, 5, 0};
        vecs[3] = '{16,  16, 1, 21'h000400, 1, 21, 0, 12'h000, 8, 1};
        vecs[4] = '{1,   1,  0, 21'h000010, 1, 3,  1, 12'hFFF, 1, 0};
        vecs[5] = '{0,   0,  0, 21'h000500, 1, 3,  0, 12'h000, 0, 0};
        vecs[6] = '{8,   8,  0, 21'h1FFFF8, 1, 3,  0, 12'h000, 8, 0};

        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clk_PSRAM);
        #1;
        rst = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) begin
            run(vecs[v]);
            repeat (2) tick();
        end

        // Reset in the middle of a capture while a burst request is outstanding.
        ack_lat = 50;
        exp_q.push_back('{addr: 21'h000300, data: 64'h0004_0003_0002_0001});
        acq_num_samples = 24'd100;
        acq_base_addr = 21'h000300;
        acq_start = 1'b1;
        tick();
        acq_start = 1'b0;
        done_cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            adc_data = 12'(i);
            adc_OTR = 1'b0;
            adc_ready = 1'b1;
            tick();
        end
        adc_ready = 1'b0;
        check("midrun_req_high", 64'(psram_wr_req), 64'(1));
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("midrun_rst");
        repeat (2) @(posedge clk_PSRAM);
        #1;
        rst = 1'b0;
        tick();
        check("midrun_no_done", 64'(done_cnt), 64'(0));
        check("midrun_queue", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        run('{4, 4, 0, 21'h000200, 1, 3, 0, 12'h000, 4, 0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
